cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//   Shares the single CDB between functional units that finish in the same cycle. Each FU owns a
//   1-entry holding slot; a round-robin arbiter broadcasts one completed tag per cycle.
//   cdb_valid/cdb_tag drive the RS CAM_en/CDB_in pair and the map-table/ROB wakeup.
//   Returns per-FU back-pressure so an FU holds its result until the CDB accepts it.
// PARAMETERS
//   NUM_REQ  4  number of requesting FUs (0=ALU, 1=MULT, 2=LD, 3=BR)
//   TAG_W    6  physical-register tag width ($clog2(`NUM_PHYS_REG))
//   CNT_W    16 width of the stall performance counter
// PORTS
//   clock        in   1              system clock, all state on posedge
//   reset        in   1              synchronous, active-low reset
//   fu_done      in   NUM_REQ        FU i presents a completed result this cycle
//   fu_tag       in   NUM_REQ*TAG_W  destination tag of FU i (slice i*TAG_W +: TAG_W)
//   fu_stall     out  NUM_REQ        FU i must hold fu_done/fu_tag stable (result not accepted)
//   cdb_valid    out  1              broadcast valid (to RS CAM_en)
//   cdb_tag      out  TAG_W          broadcast tag (to RS CDB_in); all-ones (DUMMY_REG) when idle
//   cdb_src      out  $clog2(NUM_REQ) index of FU whose tag is on the CDB
//   stall_cycles out  CNT_W          saturating count of cycles with any fu_stall bit set
// BEHAVIOUR
//   - Reset (reset==0 at posedge): all slots invalid, rr_ptr=0, cdb_valid=0, cdb_tag='1,
//     cdb_src=0, stall_cycles=0; fu_stall=0 the following cycle. Pending results are dropped;
//     reset mid-operation loses in-flight tags by design (pipeline flushed).
//   - Slot i state: hold_valid[i], hold_tag[i].
//   - Grant (comb): among hold_valid, first index at or after rr_ptr (wrapping mod NUM_REQ).
//     At most one grant per cycle. No valid slot -> no grant.
//   - Outputs are registered: slot granted in cycle N -> cdb_valid=1, cdb_tag=hold_tag,
//     cdb_src=i in cycle N+1 (valid for exactly one cycle per granted slot). No grant -> cdb_valid=0,
//     cdb_tag='1.
//   - rr_ptr <= (grant_idx+1) mod NUM_REQ on a grant; unchanged otherwise.
//   - fu_stall[i] = hold_valid[i] & ~grant[i] (comb). Accept = fu_done[i] & ~fu_stall[i].
//   - Slot update: accept -> hold_valid=1, hold_tag=fu_tag[i]; else grant -> hold_valid=0;
//     else hold. Grant and new accept in the same cycle refill the slot (no bubble).
//   - Latency: fu_done accepted in cycle N -> earliest broadcast cycle N+2 (capture N+1 edge, grant
//     in N+1, broadcast N+2). Worst case with all NUM_REQ slots full: NUM_REQ+1 cycles.
//   - Round-robin guarantees each valid slot is granted within NUM_REQ cycles (no starvation).
//   - fu_done with fu_stall set is ignored (FU must re-present); fu_tag ignored when fu_done=0.
//   - stall_cycles increments when |fu_stall, saturates at all-ones, never wraps.
//   - All-full: every slot valid -> exactly one drains per cycle, NUM_REQ-1 FUs see fu_stall.
// CONFIGURATION
//   CDB_FIXED_PRIO_EN defined: grant = lowest valid index (ALU highest priority); rr_ptr unused
//     and held at 0; starvation of high indices possible and accepted.
//   Undefined (default): round-robin as above.
// TESTING
//   1 Reset: reset=0 two cycles with fu_done=4'b1111 -> cdb_valid=0, cdb_tag=6'h3F,
//     fu_stall=0, stall_cycles=0.
//   2 Single: fu_done[0]=1, fu_tag[0]=3 at N -> cdb_valid=1, cdb_tag=3, cdb_src=0 at N+2 only.
//   3 Contention: fu_done=4'b1111, tags 5,6,7,8 same cycle, then 0 -> broadcasts 5,6,7,8 on
//     four consecutive cycles; fu_stall pattern 1110,1100,1000; stall_cycles=3.
//   4 Fairness: ALU re-presents a new tag every cycle while MULT holds tag 9 -> tag 9 broadcast
//     within 2 cycles; ALU/MULT alternate (with CDB_FIXED_PRIO_EN: ALU wins every cycle, MULT stalls).
//   5 Refill: slot 1 granted while fu_done[1]=1 tag 12 -> no stall, 12 broadcast 2 cycles later.
//   6 Mid-op reset: 3 slots full, reset=0 one cycle -> no later broadcast of those tags, rr_ptr=0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-FU one-entry holding slots, one registered broadcast per cycle.
// Define CDB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 6,
  parameter int CNT_W   = 16,
  localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       fu_done,
  input  logic [NUM_REQ*TAG_W-1:0] fu_tag,
  output logic [NUM_REQ-1:0]       fu_stall,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [SRC_W-1:0]         cdb_src,
  output logic [CNT_W-1:0]         stall_cycles
);

  logic [NUM_REQ-1:0] hold_valid_q, hold_valid_d;
  logic [TAG_W-1:0]   hold_tag_q [NUM_REQ];
  logic [TAG_W-1:0]   hold_tag_d [NUM_REQ];
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

  logic [NUM_REQ-1:0] grant_s;
  logic [NUM_REQ-1:0] accept_s;
  logic               grant_any_s;
  logic [SRC_W-1:0]   grant_idx_s;
`ifndef CDB_FIXED_PRIO_EN
  logic [SRC_W:0]     scan_s;
`endif

  // Grant selection: first valid slot at/after rr_ptr, or lowest index in fixed mode
  always_comb begin
    grant_s     = '0;
    grant_any_s = 1'b0;
    grant_idx_s = '0;
`ifdef CDB_FIXED_PRIO_EN
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hold_valid_q[k]) begin
        grant_any_s = 1'b1;
        grant_idx_s = SRC_W'(k);
      end else begin
        grant_any_s = grant_any_s;
      end
    end
`else
    scan_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_s = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (scan_s >= (SRC_W+1)'(NUM_REQ)) begin
        scan_s = scan_s - (SRC_W+1)'(NUM_REQ);
      end else begin
        scan_s = scan_s;
      end
      if (!grant_any_s && hold_valid_q[scan_s[SRC_W-1:0]]) begin
        grant_any_s = 1'b1;
        grant_idx_s = scan_s[SRC_W-1:0];
      end else begin
        grant_any_s = grant_any_s;
      end
    end
`endif
    if (grant_any_s) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign fu_stall = hold_valid_q & ~grant_s;
  assign accept_s = fu_done & ~fu_stall;

  // Next-state: slot refill/drain, pointer advance, broadcast and stall counter
  always_comb begin
    hold_valid_d   = hold_valid_q;
    hold_tag_d     = hold_tag_q;
    rr_ptr_d       = rr_ptr_q;
    stall_cycles_d = stall_cycles_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept_s[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_tag_d[i]   = fu_tag[i*TAG_W +: TAG_W];
      end else if (grant_s[i]) begin
        hold_valid_d[i] = 1'b0;
      end else begin
        hold_valid_d[i] = hold_valid_q[i];
      end
    end
`ifdef CDB_FIXED_PRIO_EN
    rr_ptr_d = '0;
`else
    if (grant_any_s) begin
      rr_ptr_d = (grant_idx_s == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + SRC_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
`endif
    cdb_valid_d = grant_any_s;
    if (grant_any_s) begin
      cdb_tag_d = hold_tag_q[grant_idx_s];
      cdb_src_d = grant_idx_s;
    end else begin
      cdb_tag_d = '1;
      cdb_src_d = '0;
    end
    // Counter saturates rather than wrapping
    if ((|fu_stall) && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // State registers with synchronous active-low reset; pending results are dropped
  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_valid_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        hold_tag_q[i] <= '0;
      end
      rr_ptr_q       <= '0;
      cdb_valid_q    <= 1'b0;
      cdb_tag_q      <= '1;
      cdb_src_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      hold_valid_q   <= hold_valid_d;
      hold_tag_q     <= hold_tag_d;
      rr_ptr_q       <= rr_ptr_d;
      cdb_valid_q    <= cdb_valid_d;
      cdb_tag_q      <= cdb_tag_d;
      cdb_src_q      <= cdb_src_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_tag_q;
  assign cdb_src      = cdb_src_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: per-cycle comparison against a slot/queue model plus literal checks.
module tb_cdb_arbiter;

  logic        clock;
  logic        reset_s;
  logic [3:0]  fu_done_s;
  logic [23:0] fu_tag_s;
  logic [3:0]  fu_stall;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [1:0]  cdb_src;
  logic [15:0] stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  cdb_arbiter #(.NUM_REQ(4), .TAG_W(6), .CNT_W(16)) dut (
    .clock(clock), .reset(reset_s), .fu_done(fu_done_s), .fu_tag(fu_tag_s),
    .fu_stall(fu_stall), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_src(cdb_src), .stall_cycles(stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: pending result per FU, next-turn pointer, expected broadcast and stall count
  bit       model_ok = 1'b0;
  bit       m_pend [4];
  int       m_ptag [4];
  int       m_next;
  bit       m_valid;
  int       m_tag;
  int       m_src;
  int       m_cnt;

  function automatic int pick();
    int w;
    w = -1;
`ifdef CDB_FIXED_PRIO_EN
    for (int k = 3; k >= 0; k--) if (m_pend[k]) w = k;
`else
    for (int k = 3; k >= 0; k--) if (m_pend[(m_next + k) % 4]) w = (m_next + k) % 4;
`endif
    return w;
  endfunction

  function automatic logic [3:0] exp_stall();
    logic [3:0] s;
    int g;
    g = pick();
    for (int i = 0; i < 4; i++) s[i] = m_pend[i] && (i != g);
    return s;
  endfunction

  always @(posedge clock) begin
    int g;
    logic [3:0] st;
    if (!reset_s) begin
      model_ok <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        m_pend[i] <= 1'b0;
        m_ptag[i] <= 0;
      end
      m_next  <= 0;
      m_valid <= 1'b0;
      m_tag   <= 63;
      m_src   <= 0;
      m_cnt   <= 0;
    end else if (model_ok) begin
      g  = pick();
      st = exp_stall();
      m_valid <= (g >= 0);
      m_tag   <= (g >= 0) ? m_ptag[g] : 63;
      m_src   <= (g >= 0) ? g : 0;
      if (st != 4'b0000 && m_cnt < 65535) m_cnt <= m_cnt + 1;
      for (int i = 0; i < 4; i++) begin
        if (fu_done_s[i] && !st[i]) begin
          m_pend[i] <= 1'b1;
          m_ptag[i] <= int'(fu_tag_s[i*6 +: 6]);
        end else if (i == g) begin
          m_pend[i] <= 1'b0;
        end
      end
`ifdef CDB_FIXED_PRIO_EN
      m_next <= 0;
`else
      if (g >= 0) m_next <= (g + 1) % 4;
`endif
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the active edge
  always @(negedge clock) begin
    if (model_ok) begin
      n_tests++;
      if (fu_stall !== exp_stall()) begin
        n_fail++;
        $display("FAIL model_stall t=%0t got=%b exp=%b", $time, fu_stall, exp_stall());
      end
      n_tests++;
      if (cdb_valid !== m_valid || int'(cdb_tag) != m_tag || $isunknown(cdb_tag)) begin
        n_fail++;
        $display("FAIL model_cdb t=%0t got=%b/%0d exp=%b/%0d", $time, cdb_valid, cdb_tag, m_valid, m_tag);
      end
      if (m_valid) begin
        n_tests++;
        if (int'(cdb_src) != m_src || $isunknown(cdb_src)) begin
          n_fail++;
          $display("FAIL model_src t=%0t got=%0d exp=%0d", $time, cdb_src, m_src);
        end
      end
      n_tests++;
      if (int'(stall_cycles) != m_cnt || $isunknown(stall_cycles)) begin
        n_fail++;
        $display("FAIL model_cnt t=%0t got=%0d exp=%0d", $time, stall_cycles, m_cnt);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] d,
                      input int t0, input int t1, input int t2, input int t3);
    @(negedge clock);
    reset_s   = r;
    fu_done_s = d;
    fu_tag_s  = {6'(t3), 6'(t2), 6'(t1), 6'(t0)};
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 4'b0000, 0, 0, 0, 0);
  endtask

  initial begin
    reset_s   = 1'b0;
    fu_done_s = 4'b0000;
    fu_tag_s  = 24'h000000;

    // Reset held two cycles with all FUs requesting
    step(1'b0, 4'b1111, 1, 2, 3, 4);
    step(1'b0, 4'b1111, 1, 2, 3, 4);
    step(1'b1, 4'b0000, 0, 0, 0, 0);
    chk("rst_valid", int'(cdb_valid), 0);
    chk("rst_tag", int'(cdb_tag), 63);
    chk("rst_stall", int'(fu_stall), 0);
    chk("rst_cnt", int'(stall_cycles), 0);

    // Single request: broadcast two cycles later, exactly once
    step(1'b1, 4'b0001, 3, 0, 0, 0);
    step(1'b1, 4'b0000, 0, 0, 0, 0);
    chk("single_early", int'(cdb_valid), 0);
    step(1'b1, 4'b0000, 0, 0, 0, 0);
    chk("single_valid", int'(cdb_valid), 1);
    chk("single_tag", int'(cdb_tag), 3);
    chk("single_src", int'(cdb_src), 0);
    step(1'b1, 4'b0000, 0, 0, 0, 0);
    chk("single_once", int'(cdb_valid), 0);

    // Contention from a fresh pointer
    step(1'b0, 4'b0000, 0, 0, 0, 0);
    step(1'b1, 4'b1111, 5, 6, 7, 8);
    step(1'b1, 4'b0000, 0, 0, 0, 0);
    chk("cont_stall0", int'(fu_stall), 4'b1110);
    step(1'b1, 4'b0000, 0, 0, 0, 0);
    chk("cont_tag5", int'(cdb_tag), 5);
    chk("cont_stall1", int'(fu_stall), 4'b1100);
    step(1'b1, 4'b0000, 0, 0, 0, 0);
    chk("cont_tag6", int'(cdb_tag), 6);
    chk("cont_stall2", int'(fu_stall), 4'b1000);
    step(1'b1, 4'b0000, 0, 0, 0, 0);
    chk("cont_tag7", int'(cdb_tag), 7);
    chk("cont_stall3", int'(fu_stall), 4'b0000);
    step(1'b1, 4'b0000, 0, 0, 0, 0);
    chk("cont_tag8", int'(cdb_tag), 8);
    chk("cont_valid8", int'(cdb_valid), 1);
    chk("cont_cnt", int'(stall_cycles), 3);
    idle(2);

    // Fairness: ALU streams new tags while MULT holds tag 9
    step(1'b1, 4'b0011, 20, 9, 0, 0);
    step(1'b1, 4'b0001, 21, 0, 0, 0);
    step(1'b1, 4'b0001, 22, 0, 0, 0);
    chk("fair_first", int'(cdb_tag), 20);
    step(1'b1, 4'b0001, 23, 0, 0, 0);
`ifdef CDB_FIXED_PRIO_EN
    chk("fair_second", int'(cdb_tag), 21);
    chk("fair_src", int'(cdb_src), 0);
`else
    chk("fair_second", int'(cdb_tag), 9);
    chk("fair_src", int'(cdb_src), 1);
`endif
    step(1'b1, 4'b0001, 24, 0, 0, 0);
    idle(8);

    // Refill: granted slot accepts a new result in the same cycle
    step(1'b1, 4'b0010, 0, 11, 0, 0);
    step(1'b1, 4'b0010, 0, 12, 0, 0);
    chk("refill_nostall", int'(fu_stall), 0);
    step(1'b1, 4'b0000, 0, 0, 0, 0);
    chk("refill_tag11", int'(cdb_tag), 11);
    step(1'b1, 4'b0000, 0, 0, 0, 0);
    chk("refill_tag12", int'(cdb_tag), 12);
    chk("refill_valid", int'(cdb_valid), 1);
    idle(2);

    // Mid-operation reset drops in-flight tags and restarts the pointer
    step(1'b1, 4'b0111, 30, 31, 32, 0);
    step(1'b0, 4'b0000, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b0000, 0, 0, 0, 0);
      chk("flush_quiet", int'(cdb_valid), 0);
    end
    step(1'b1, 4'b1001, 40, 0, 0, 41);
    step(1'b1, 4'b0000, 0, 0, 0, 0);
    step(1'b1, 4'b0000, 0, 0, 0, 0);
    chk("flush_ptr_tag", int'(cdb_tag), 40);
    chk("flush_ptr_src", int'(cdb_src), 0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
